// File: rtl/pwm_ctrl.sv
// pwm_ctrl
// Sequencer and configuration front-end for the PWM period counter.
// A prescaler produces a tick every (prescale+1) clocks. Each tick advances
// the period counter, which wraps after (period+1) ticks. The period/duty/
// prescale set is double-buffered: software loads a pending copy through a
// valid/ready handshake, and the active copy is replaced only in IDLE or on
// a period wrap, so a running waveform never changes shape mid-period.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle request to begin (or to resume from DRAIN)
//   stop          one-cycle request to finish the current period, then idle
//   cfg_valid     configuration word valid
//   cfg_ready     pending slot empty; a word is taken when valid && ready
//   cfg_period    terminal count; period is cfg_period+1 ticks
//   cfg_duty      high time in ticks
//   cfg_prescale  tick every cfg_prescale+1 clocks
//   count         current period counter value
//   tick          counter advance strobe
//   pwm_out       PWM waveform
//   period_done   one-cycle pulse in the cycle after a period wrap
//   busy          high in RUN or DRAIN
module pwm_ctrl #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic [PRE_W-1:0] cfg_prescale,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             pwm_out,
    output logic             period_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] period;
        logic [WIDTH-1:0] duty;
        logic [PRE_W-1:0] prescale;
    } cfg_t;

    state_t           state_q;
    state_t           state_d;
    cfg_t             active_q;
    cfg_t             pend_q;
    logic             pend_valid_q;
    logic [PRE_W-1:0] presc_cnt_q;
    logic [WIDTH-1:0] count_q;
    logic             period_done_q;

    logic             boundary;
    logic             accept;
    logic             apply;

    // Outputs and strobes are decoded from registered state only.
    assign busy        = (state_q != IDLE);
    assign tick        = busy && (presc_cnt_q == active_q.prescale);
    assign boundary    = tick && (count_q == active_q.period);
    assign cfg_ready   = !pend_valid_q;
    assign accept      = cfg_valid && cfg_ready;
    // In IDLE there is no waveform to protect, so the pending word goes
    // live immediately; otherwise it waits for the wrapping tick.
    assign apply       = pend_valid_q && ((state_q == IDLE) || boundary);
    assign count       = count_q;
    assign period_done = period_done_q;
    assign pwm_out     = busy && (count_q < active_q.duty);

    // NOTE: every signal written in an always_comb gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // stop beats start when both arrive together.
                if (start && !stop) begin
                    state_d = RUN;
                end else if (boundary) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Prescaler and period counter. Leaving DRAIN always coincides with a
    // wrapping tick, so both counters are already heading to zero then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q   <= '0;
            count_q       <= '0;
            period_done_q <= 1'b0;
        end else begin
            period_done_q <= boundary;
            if (!busy) begin
                presc_cnt_q <= '0;
                count_q     <= '0;
            end else if (tick) begin
                presc_cnt_q <= '0;
                count_q     <= (count_q == active_q.period) ? '0 : count_q + 1'b1;
            end else begin
                presc_cnt_q <= presc_cnt_q + 1'b1;
            end
        end
    end

    // Double-buffered configuration. accept requires an empty slot and apply
    // requires a full one, so the two never fire in the same cycle.
    // NOTE: the active set is reset to a defined value (longest period, zero
    // duty, no prescale) so a start without any prior configuration still
    // produces a benign, predictable waveform.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q.period   <= '1;
            active_q.duty     <= '0;
            active_q.prescale <= '0;
            pend_q            <= '0;
            pend_valid_q      <= 1'b0;
        end else begin
            if (accept) begin
                pend_q.period   <= cfg_period;
                pend_q.duty     <= cfg_duty;
                pend_q.prescale <= cfg_prescale;
                pend_valid_q    <= 1'b1;
            end else if (apply) begin
                active_q     <= pend_q;
                pend_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ctrl.sv
// Directed testbench for pwm_ctrl. Inputs change 1 ns after a rising edge
// and outputs are sampled at the same point, away from the active edge.
module tb_pwm_ctrl;

    localparam int WIDTH = 8;
    localparam int PRE_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_duty;
    logic [PRE_W-1:0] cfg_prescale;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             pwm_out;
    logic             period_done;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    pwm_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_prescale (cfg_prescale),
        .count        (count),
        .tick         (tick),
        .pwm_out      (pwm_out),
        .period_done  (period_done),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        start        = 1'b0;
        stop         = 1'b0;
        cfg_valid    = 1'b0;
        cfg_period   = '0;
        cfg_duty     = '0;
        cfg_prescale = '0;
        rst_n        = 1'b0;
        step_n(2);
        rst_n = 1'b1;
        step();
    endtask

    // Present a word and hold it until the edge on which it is taken.
    task automatic send_cfg(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d,
                            input logic [PRE_W-1:0] ps);
        int waited;
        waited       = 0;
        cfg_valid    = 1'b1;
        cfg_period   = p;
        cfg_duty     = d;
        cfg_prescale = ps;
        while (cfg_ready !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL cfg_accept_timeout: cfg_ready=%b after %0d cycles, expected 1", cfg_ready, waited);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        cfg_period = '0; cfg_duty = '0; cfg_prescale = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        step_n(2);
        n_checks++;
        if (count !== 8'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if (tick !== 1'b0) begin n_errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
        n_checks++;
        if (pwm_out !== 1'b0) begin n_errors++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
        n_checks++;
        if (period_done !== 1'b0) begin n_errors++; $display("FAIL reset_period_done: got %b expected 0", period_done); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
        rst_n = 1'b1;
        step_n(2);
        n_checks++;
        if (busy !== 1'b0 || count !== 8'd0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy=%b count=%0d expected busy=0 count=0", busy, count);
        end
    endtask

    task automatic test_basic();
        int highs;
        int dones;
        do_reset();
        send_cfg(8'd9, 8'd3, 8'd0);
        n_checks++;
        if (cfg_ready !== 1'b0) begin n_errors++; $display("FAIL basic_pending_ready: got %b expected 0", cfg_ready); end
        step();
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL basic_applied_ready: got %b expected 1", cfg_ready); end
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (count !== WIDTH'(i) || pwm_out !== (i < 3) || tick !== 1'b1 || busy !== 1'b1 || period_done !== 1'b0) begin
                n_errors++;
                $display("FAIL basic_cycle%0d: count=%0d pwm=%b tick=%b busy=%b pd=%b expected count=%0d pwm=%b tick=1 busy=1 pd=0",
                         i, count, pwm_out, tick, busy, period_done, i, (i < 3));
            end
            step();
        end
        n_checks++;
        if (count !== 8'd0 || period_done !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_wrap: count=%0d pd=%b expected count=0 pd=1", count, period_done);
        end
        highs = 0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (pwm_out === 1'b1) highs++;
            if (period_done === 1'b1) dones++;
            step();
        end
        n_checks++;
        if (highs != 3 || dones != 1) begin
            n_errors++;
            $display("FAIL basic_second_period: high=%0d done=%0d expected high=3 done=1", highs, dones);
        end
    endtask

    task automatic test_prescale();
        do_reset();
        send_cfg(8'd3, 8'd2, 8'd4);
        step();
        pulse_start();
        for (int j = 0; j < 20; j++) begin
            n_checks++;
            if (count !== WIDTH'(j / 5) || tick !== ((j % 5) == 4) || pwm_out !== (j < 10)) begin
                n_errors++;
                $display("FAIL prescale_cycle%0d: count=%0d tick=%b pwm=%b expected count=%0d tick=%b pwm=%b",
                         j, count, tick, pwm_out, j / 5, ((j % 5) == 4), (j < 10));
            end
            step();
        end
        n_checks++;
        if (count !== 8'd0 || period_done !== 1'b1) begin
            n_errors++;
            $display("FAIL prescale_wrap: count=%0d pd=%b expected count=0 pd=1", count, period_done);
        end
    endtask

    task automatic test_boundary_update();
        do_reset();
        send_cfg(8'd9, 8'd3, 8'd0);
        step();
        pulse_start();
        step_n(4);
        send_cfg(8'd9, 8'd7, 8'd0);
        for (int i = 5; i < 10; i++) begin
            n_checks++;
            if (count !== WIDTH'(i) || pwm_out !== 1'b0 || cfg_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL update_hold_cycle%0d: count=%0d pwm=%b ready=%b expected count=%0d pwm=0 ready=0",
                         i, count, pwm_out, cfg_ready, i);
            end
            step();
        end
        n_checks++;
        if (count !== 8'd0 || period_done !== 1'b1 || cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL update_wrap: count=%0d pd=%b ready=%b expected count=0 pd=1 ready=1",
                     count, period_done, cfg_ready);
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (count !== WIDTH'(i) || pwm_out !== (i < 7)) begin
                n_errors++;
                $display("FAIL update_new_duty_cycle%0d: count=%0d pwm=%b expected count=%0d pwm=%b",
                         i, count, pwm_out, i, (i < 7));
            end
            step();
        end
    endtask

    task automatic test_extremes();
        do_reset();
        send_cfg(8'd9, 8'd0, 8'd0);
        step();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (pwm_out !== 1'b0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL duty0_cycle%0d: pwm=%b busy=%b expected pwm=0 busy=1", i, pwm_out, busy);
            end
            step();
        end

        do_reset();
        send_cfg(8'd9, 8'd12, 8'd0);
        step();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (pwm_out !== 1'b1) begin
                n_errors++;
                $display("FAIL duty_over_period_cycle%0d: pwm=%b expected 1", i, pwm_out);
            end
            step();
        end

        do_reset();
        send_cfg(8'd0, 8'd1, 8'd0);
        step();
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (count !== 8'd0 || pwm_out !== 1'b1 || tick !== 1'b1 || period_done !== (k != 0)) begin
                n_errors++;
                $display("FAIL period0_cycle%0d: count=%0d pwm=%b tick=%b pd=%b expected count=0 pwm=1 tick=1 pd=%b",
                         k, count, pwm_out, tick, period_done, (k != 0));
            end
            step();
        end
    endtask

    task automatic test_stop_start();
        do_reset();
        send_cfg(8'd9, 8'd3, 8'd0);
        step();
        pulse_start();
        step_n(4);
        n_checks++;
        if (count !== 8'd4) begin n_errors++; $display("FAIL stop_setup_count: got %0d expected 4", count); end
        pulse_stop();
        step_n(4);
        n_checks++;
        if (count !== 8'd9 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_running: count=%0d busy=%b expected count=9 busy=1", count, busy);
        end
        step();
        n_checks++;
        if (count !== 8'd0 || busy !== 1'b0 || period_done !== 1'b1 || pwm_out !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_end: count=%0d busy=%b pd=%b pwm=%b expected count=0 busy=0 pd=1 pwm=0",
                     count, busy, period_done, pwm_out);
        end
        step_n(3);
        n_checks++;
        if (count !== 8'd0 || busy !== 1'b0 || tick !== 1'b0 || period_done !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_hold: count=%0d busy=%b tick=%b pd=%b expected 0 0 0 0",
                     count, busy, tick, period_done);
        end

        pulse_start();
        step_n(2);
        pulse_stop();
        step();
        pulse_start();
        n_checks++;
        if (count !== 8'd5 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL resume_count: count=%0d busy=%b expected count=5 busy=1", count, busy);
        end
        step_n(5);
        n_checks++;
        if (count !== 8'd0 || busy !== 1'b1 || period_done !== 1'b1) begin
            n_errors++;
            $display("FAIL resume_past_wrap: count=%0d busy=%b pd=%b expected count=0 busy=1 pd=1",
                     count, busy, period_done);
        end
        step();
        n_checks++;
        if (count !== 8'd1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL resume_next_period: count=%0d busy=%b expected count=1 busy=1", count, busy);
        end

        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        step_n(7);
        n_checks++;
        if (count !== 8'd9 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL both_before_wrap: count=%0d busy=%b expected count=9 busy=1", count, busy);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || count !== 8'd0) begin
            n_errors++;
            $display("FAIL both_stop_wins: busy=%b count=%0d expected busy=0 count=0", busy, count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_cfg(8'd9, 8'd3, 8'd0);
        step();
        pulse_start();
        step_n(4);
        send_cfg(8'd4, 8'd1, 8'd0);
        n_checks++;
        if (count !== 8'd5 || cfg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL arst_setup: count=%0d ready=%b expected count=5 ready=0", count, cfg_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 8'd0 || tick !== 1'b0 || pwm_out !== 1'b0 || period_done !== 1'b0 ||
            busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL arst_immediate: count=%0d tick=%b pwm=%b pd=%b busy=%b ready=%b expected 0 0 0 0 0 1",
                     count, tick, pwm_out, period_done, busy, cfg_ready);
        end
        #2 rst_n = 1'b1;
        step();
        n_checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL arst_release: ready=%b busy=%b expected ready=1 busy=0", cfg_ready, busy);
        end
        // With the pending word discarded, the reset defaults are live:
        // duty 0 and a 256-tick period.
        pulse_start();
        n_checks++;
        if (pwm_out !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL arst_default_duty: pwm=%b busy=%b expected pwm=0 busy=1", pwm_out, busy);
        end
        step_n(255);
        n_checks++;
        if (count !== 8'd255 || period_done !== 1'b0) begin
            n_errors++;
            $display("FAIL arst_default_period: count=%0d pd=%b expected count=255 pd=0", count, period_done);
        end
        step();
        n_checks++;
        if (count !== 8'd0 || period_done !== 1'b1) begin
            n_errors++;
            $display("FAIL arst_default_wrap: count=%0d pd=%b expected count=0 pd=1", count, period_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescale();
        test_boundary_update();
        test_extremes();
        test_stop_start();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
